// File: rtl/seq_scan_ctrl_pkg.sv
// rtl/seq_scan_ctrl_pkg.sv - shared types, constants and helpers for the scan controller
// Purpose: FSM state encoding, default detector pattern, clog2 helper for width checks.
// Ports: none (package).
package seq_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [2:0] DEFAULT_PATTERN = 3'b101;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// rtl/seq_scan_ctrl_if.sv - request/response bundle between host and scan controller
// Purpose: groups the scan request (start, data_in, pattern, overlap) and status outputs.
// Ports: none; master modport drives the request, slave modport is the controller side.
interface seq_scan_ctrl_if #(
  parameter int WORD_W = 16,
  parameter int PAT_W  = 3,
  parameter int CNT_W  = 5
);
  logic              start;
  logic [WORD_W-1:0] data_in;
  logic [PAT_W-1:0]  pattern;
  logic              overlap;
  logic              busy;
  logic              hit;
  logic              done;
  logic [CNT_W-1:0]  match_count;

  modport master (
    output start, data_in, pattern, overlap,
    input  busy, hit, done, match_count
  );

  modport slave (
    input  start, data_in, pattern, overlap,
    output busy, hit, done, match_count
  );
endinterface

// File: rtl/seq_scan_ctrl_win_match.sv
// rtl/seq_scan_ctrl_win_match.sv - serial window shift register and pattern comparator
// Purpose: tracks the last PAT_W bits and how many valid bits are in the window.
// Ports: clk, arst (async active-low), clr (start of scan), en (shift one bit),
//        bit_in, pattern, overlap; match is combinational and qualified by en.
module seq_win_match
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = 3
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match
);
  localparam int FILL_W = clog2(PAT_W + 1);

  // Only PAT_W-1 history bits are stored; the newest bit comes straight from bit_in.
  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  win_next;
  logic [FILL_W-1:0] fill_next;

  always_comb begin
    win_next  = {hist, bit_in};
    fill_next = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;
    match     = en && (fill_next == FILL_W'(PAT_W)) && (win_next == pattern);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= win_next[PAT_W-2:0];
      // Non-overlapping: a match consumes its bits, so refill from empty.
      fill <= (match && !overlap) ? '0 : fill_next;
    end
  end
endmodule

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - sequences a captured word MSB-first through a pattern detector
// Purpose: IDLE/SHIFT/DONE FSM, data shift register, bit counter, match counter.
// Ports: clk, arst (async active-low), bus (slave modport: start, data_in, pattern,
//        overlap in; busy, hit, done, match_count out).
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int PAT_W  = 3,
  parameter int CNT_W  = 5
) (
  input logic           clk,
  input logic           arst,
  seq_scan_ctrl_if.slave bus
);
  localparam int BIT_W = clog2(WORD_W);

  if (CNT_W < clog2(WORD_W + 1)) begin : g_cnt_w_check
    $error("CNT_W too narrow to hold WORD_W matches");
  end

  state_t            state, state_next;
  logic [WORD_W-1:0] shreg;
  logic [PAT_W-1:0]  pat_q;
  logic              ovl_q;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cnt;
  logic              hit_q;
  logic              accept;
  logic              shift_en;
  logic              match;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    shift_en   = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        bus.busy = 1'b1;
        if (bit_cnt == '0) state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      shreg   <= '0;
      pat_q   <= PAT_W'(DEFAULT_PATTERN);
      ovl_q   <= 1'b0;
      bit_cnt <= '0;
      cnt     <= '0;
      hit_q   <= 1'b0;
    end else begin
      hit_q <= match;
      if (accept) begin
        shreg   <= bus.data_in;
        pat_q   <= bus.pattern;
        ovl_q   <= bus.overlap;
        cnt     <= '0;
        bit_cnt <= BIT_W'(WORD_W - 1);
      end else if (shift_en) begin
        shreg <= shreg << 1;
        if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
        // Cannot wrap: at most WORD_W-PAT_W+1 matches per word.
        if (match) cnt <= cnt + 1'b1;
      end
    end
  end

  seq_win_match #(.PAT_W(PAT_W)) u_win (
    .clk     (clk),
    .arst    (arst),
    .clr     (accept),
    .en      (shift_en),
    .bit_in  (shreg[WORD_W-1]),
    .pattern (pat_q),
    .overlap (ovl_q),
    .match   (match)
  );

  assign bus.hit         = hit_q;
  assign bus.match_count = cnt;
endmodule
